// File: rtl/otter_csr_int.sv
// Machine-mode CSR file and external-interrupt unit for the OTTER MCU.
// Holds mstatus/mie/mtvec/mepc/mcause and raises INT_PENDING for the control FSM.
module otter_csr_int #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] MCAUSE_EXT  = 32'h8000000B
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        INTR,
    input  logic        INT_TAKEN,
    input  logic        MRET_EXEC,
    input  logic        CSR_WE,
    input  logic [11:0] ADDR,
    input  logic [31:0] WD,
    input  logic [31:0] PC,
    output logic [31:0] RD,
    output logic [31:0] MEPC,
    output logic [31:0] MTVEC,
    output logic        MIE_BIT,
    output logic        INT_PENDING
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   hist_reg;
    logic                   pending_reg, pending_next;
    logic                   mie_reg, mie_next;
    logic                   mpie_reg, mpie_next;
    logic                   meie_reg, meie_next;
    logic [31:2]            mtvec_reg, mtvec_next;
    logic [31:2]            mepc_reg, mepc_next;
    logic [31:0]            mcause_reg, mcause_next;
    logic                   sync_out;
    logic                   rise;

    // Synchronizer chain for the asynchronous interrupt line.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge CLK) begin
                    if (RST) sync_reg[gi] <= 1'b0;
                    else     sync_reg[gi] <= INTR;
                end
            end else begin : g_rest
                always_ff @(posedge CLK) begin
                    if (RST) sync_reg[gi] <= 1'b0;
                    else     sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign sync_out = sync_reg[SYNC_STAGES-1];
    assign rise     = sync_out & ~hist_reg;

    always_comb begin
        pending_next = pending_reg;
        mie_next     = mie_reg;
        mpie_next    = mpie_reg;
        meie_next    = meie_reg;
        mtvec_next   = mtvec_reg;
        mepc_next    = mepc_reg;
        mcause_next  = mcause_reg;

        // Only the CSR write path touches mtvec and mie, so those always commit.
        if (CSR_WE && ADDR == ADDR_MIE)   meie_next  = WD[11];
        if (CSR_WE && ADDR == ADDR_MTVEC) mtvec_next = WD[31:2];

        if (INT_TAKEN) begin
            mepc_next   = PC[31:2];
            mcause_next = MCAUSE_EXT;
            mpie_next   = mie_reg;
            mie_next    = 1'b0;
        end else begin
            if (CSR_WE && ADDR == ADDR_MEPC)   mepc_next   = WD[31:2];
            if (CSR_WE && ADDR == ADDR_MCAUSE) mcause_next = WD;
            if (MRET_EXEC) begin
                mie_next  = mpie_reg;
                mpie_next = 1'b1;
            end else if (CSR_WE && ADDR == ADDR_MSTATUS) begin
                mie_next  = WD[3];
                mpie_next = WD[7];
            end
        end

        // A fresh edge coinciding with trap entry must not be lost.
        if (INT_TAKEN)  pending_next = rise;
        else if (rise)  pending_next = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hist_reg    <= 1'b0;
            pending_reg <= 1'b0;
            mie_reg     <= 1'b0;
            mpie_reg    <= 1'b0;
            meie_reg    <= 1'b0;
            mtvec_reg   <= '0;
            mepc_reg    <= '0;
            mcause_reg  <= '0;
        end else begin
            hist_reg    <= sync_out;
            pending_reg <= pending_next;
            mie_reg     <= mie_next;
            mpie_reg    <= mpie_next;
            meie_reg    <= meie_next;
            mtvec_reg   <= mtvec_next;
            mepc_reg    <= mepc_next;
            mcause_reg  <= mcause_next;
        end
    end

    always_comb begin
        RD = 32'h0;
        case (ADDR)
            ADDR_MSTATUS: RD = {24'h0, mpie_reg, 3'b000, mie_reg, 3'b000};
            ADDR_MIE:     RD = {20'h0, meie_reg, 11'h0};
            ADDR_MTVEC:   RD = {mtvec_reg, 2'b00};
            ADDR_MEPC:    RD = {mepc_reg, 2'b00};
            ADDR_MCAUSE:  RD = mcause_reg;
            default:      RD = 32'h0;
        endcase
    end

    assign MEPC        = {mepc_reg, 2'b00};
    assign MTVEC       = {mtvec_reg, 2'b00};
    assign MIE_BIT     = mie_reg;
    assign INT_PENDING = pending_reg & mie_reg & meie_reg;

endmodule

// File: tb/tb_otter_csr_int.sv
// Scoreboard bench for otter_csr_int: stimulus queues expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_otter_csr_int;

    logic        CLK = 1'b0;
    logic        RST, INTR, INT_TAKEN, MRET_EXEC, CSR_WE;
    logic [11:0] ADDR;
    logic [31:0] WD, PC;
    logic [31:0] RD, MEPC, MTVEC;
    logic        MIE_BIT, INT_PENDING;

    otter_csr_int #(.SYNC_STAGES(2), .MCAUSE_EXT(32'h8000000B)) dut (
        .CLK(CLK), .RST(RST), .INTR(INTR), .INT_TAKEN(INT_TAKEN),
        .MRET_EXEC(MRET_EXEC), .CSR_WE(CSR_WE), .ADDR(ADDR), .WD(WD), .PC(PC),
        .RD(RD), .MEPC(MEPC), .MTVEC(MTVEC), .MIE_BIT(MIE_BIT),
        .INT_PENDING(INT_PENDING)
    );

    always #5 CLK = ~CLK;

    localparam int S_RD = 0, S_MEPC = 1, S_MTVEC = 2, S_MIE = 3, S_PEND = 4;

    typedef struct {
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t        sb_q[$];
    string       name_q[$];
    int          checks = 0;
    int          failures = 0;
    chk_t        mon_c;
    string       mon_n;
    logic [31:0] mon_act;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            S_RD:    return RD;
            S_MEPC:  return MEPC;
            S_MTVEC: return MTVEC;
            S_MIE:   return {31'h0, MIE_BIT};
            default: return {31'h0, INT_PENDING};
        endcase
    endfunction

    always @(negedge CLK) begin
        while (sb_q.size() > 0) begin
            mon_c   = sb_q.pop_front();
            mon_n   = name_q.pop_front();
            mon_act = actual(mon_c.sel);
            checks++;
            if (mon_act !== mon_c.exp) begin
                failures++;
                $display("FAIL %s: got %h expected %h", mon_n, mon_act, mon_c.exp);
            end else begin
                $display("ok   %s: %h", mon_n, mon_act);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Queue one expectation and let the monitor's negedge sample it.
    task automatic chk(input string n, input int sel, input logic [11:0] a, input logic [31:0] e);
        chk_t c;
        if (sel == S_RD) ADDR = a;
        c.sel = sel;
        c.exp = e;
        sb_q.push_back(c);
        name_q.push_back(n);
        @(negedge CLK);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        CSR_WE = 1'b1;
        ADDR   = a;
        WD     = d;
        tick();
        CSR_WE = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST = 1'b1; INTR = 1'b1; INT_TAKEN = 1'b0; MRET_EXEC = 1'b0;
        CSR_WE = 1'b1; ADDR = 12'h305; WD = 32'hFFFF_FFFF; PC = 32'h0;
        tick();
        tick();
        RST = 1'b0; CSR_WE = 1'b0; INTR = 1'b0; WD = 32'h0;
        chk("reset_mtvec", S_MTVEC, 12'h0, 32'h0);
        chk("reset_mie_bit", S_MIE, 12'h0, 32'h0);
        chk("reset_pending", S_PEND, 12'h0, 32'h0);
        chk("reset_rd305", S_RD, 12'h305, 32'h0);
        chk("reset_mepc", S_MEPC, 12'h0, 32'h0);
        chk("reset_rd300", S_RD, 12'h300, 32'h0);

        wr(12'h305, 32'h0000_0107);
        chk("mask_mtvec", S_MTVEC, 12'h0, 32'h0000_0104);
        chk("mask_rd305", S_RD, 12'h305, 32'h0000_0104);
        wr(12'h300, 32'hFFFF_FFFF);
        chk("mask_rd300", S_RD, 12'h300, 32'h0000_0088);
        chk("mask_mie_bit", S_MIE, 12'h0, 32'h1);
        wr(12'h123, 32'h5);
        chk("unmapped_rd123", S_RD, 12'h123, 32'h0);
        wr(12'h341, 32'h0000_1003);
        chk("mask_mepc", S_MEPC, 12'h0, 32'h0000_1000);
        wr(12'h342, 32'h1234_5678);
        chk("mcause_rd342", S_RD, 12'h342, 32'h1234_5678);

        wr(12'h300, 32'h8);
        wr(12'h304, 32'h800);
        chk("mie_rd304", S_RD, 12'h304, 32'h800);
        chk("idle_pending", S_PEND, 12'h0, 32'h0);
        INTR = 1'b1;
        tick(); chk("lat_edge1", S_PEND, 12'h0, 32'h0);
        tick(); chk("lat_edge2", S_PEND, 12'h0, 32'h0);
        tick(); chk("lat_edge3", S_PEND, 12'h0, 32'h1);
        tick(); chk("lat_edge4_hold", S_PEND, 12'h0, 32'h1);

        wr(12'h304, 32'h0);
        chk("meie_masked", S_PEND, 12'h0, 32'h0);
        wr(12'h304, 32'hFFFF_FFFF);
        chk("mie_mask_rd304", S_RD, 12'h304, 32'h800);
        chk("meie_unmasked", S_PEND, 12'h0, 32'h1);

        PC = 32'h0000_1236; INT_TAKEN = 1'b1;
        tick();
        INT_TAKEN = 1'b0;
        chk("trap_mepc", S_MEPC, 12'h0, 32'h0000_1234);
        chk("trap_mcause", S_RD, 12'h342, 32'h8000_000B);
        chk("trap_mstatus", S_RD, 12'h300, 32'h0000_0080);
        chk("trap_pending", S_PEND, 12'h0, 32'h0);
        chk("trap_mie_bit", S_MIE, 12'h0, 32'h0);

        MRET_EXEC = 1'b1;
        tick();
        MRET_EXEC = 1'b0;
        chk("mret_mstatus", S_RD, 12'h300, 32'h0000_0088);
        chk("mret_mie_bit", S_MIE, 12'h0, 32'h1);
        chk("mret_mepc", S_MEPC, 12'h0, 32'h0000_1234);
        chk("no_retrigger", S_PEND, 12'h0, 32'h0);

        INTR = 1'b0;
        tick(); tick(); tick();
        INTR = 1'b1;
        tick(); tick();
        INT_TAKEN = 1'b1; CSR_WE = 1'b1; ADDR = 12'h341; WD = 32'hDEAD_BEEC; PC = 32'h0000_2000;
        tick();
        INT_TAKEN = 1'b0; CSR_WE = 1'b0;
        chk("col_mepc_pc_wins", S_MEPC, 12'h0, 32'h0000_2000);
        chk("col_mstatus", S_RD, 12'h300, 32'h0000_0080);
        chk("col_masked_pend", S_PEND, 12'h0, 32'h0);
        MRET_EXEC = 1'b1;
        tick();
        MRET_EXEC = 1'b0;
        chk("fresh_edge_kept", S_PEND, 12'h0, 32'h1);
        chk("fresh_mstatus", S_RD, 12'h300, 32'h0000_0088);

        wr(12'h342, 32'h0);
        chk("mcause_clear", S_RD, 12'h342, 32'h0);
        INT_TAKEN = 1'b1; CSR_WE = 1'b1; ADDR = 12'h305; WD = 32'h200; PC = 32'h0000_3000;
        tick();
        INT_TAKEN = 1'b0; CSR_WE = 1'b0;
        chk("col_mtvec_commits", S_MTVEC, 12'h0, 32'h200);
        chk("col2_mepc", S_MEPC, 12'h0, 32'h0000_3000);
        chk("col2_mcause", S_RD, 12'h342, 32'h8000_000B);
        MRET_EXEC = 1'b1;
        tick();
        MRET_EXEC = 1'b0;
        chk("col2_mie_bit", S_MIE, 12'h0, 32'h1);
        chk("col2_pend_cleared", S_PEND, 12'h0, 32'h0);

        wr(12'h300, 32'h80);
        chk("pre_mret_wr", S_RD, 12'h300, 32'h80);
        MRET_EXEC = 1'b1; CSR_WE = 1'b1; ADDR = 12'h300; WD = 32'h0;
        tick();
        MRET_EXEC = 1'b0; CSR_WE = 1'b0;
        chk("mret_beats_write", S_RD, 12'h300, 32'h88);
        MRET_EXEC = 1'b1; CSR_WE = 1'b1; ADDR = 12'h305; WD = 32'h400;
        tick();
        MRET_EXEC = 1'b0; CSR_WE = 1'b0;
        chk("mret_mtvec_commits", S_MTVEC, 12'h0, 32'h400);

        wr(12'h300, 32'h80);
        INT_TAKEN = 1'b1; MRET_EXEC = 1'b1; PC = 32'h0000_4000;
        tick();
        INT_TAKEN = 1'b0; MRET_EXEC = 1'b0;
        chk("int_over_mret", S_RD, 12'h300, 32'h0);
        chk("int_over_mret_mepc", S_MEPC, 12'h0, 32'h0000_4000);

        RST = 1'b1; INT_TAKEN = 1'b1; CSR_WE = 1'b1; ADDR = 12'h305;
        WD = 32'hFFFF_FFFF; PC = 32'h0000_5000;
        tick();
        RST = 1'b0; INT_TAKEN = 1'b0; CSR_WE = 1'b0;
        chk("rst_mid_mepc", S_MEPC, 12'h0, 32'h0);
        chk("rst_mid_mtvec", S_MTVEC, 12'h0, 32'h0);
        chk("rst_mid_mcause", S_RD, 12'h342, 32'h0);
        chk("rst_mid_rd304", S_RD, 12'h304, 32'h0);

        tick();
        tick();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/otter_csr_int.md
Name: otter_csr_int

Overview:
- Machine-mode CSR file and interrupt unit for the OTTER MCU.
- Consumes the SYS/MRET/interrupt control that the control-unit decoder emits; supplies the CSR read data (RF mux input 01), mepc (PC mux input 101) and mtvec (trap target) back to the datapath.
- Latches the external interrupt and tells the control FSM when one may be taken.
- Sits beside the register file; one instance per MCU.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on the asynchronous INTR input (≥2).
- MCAUSE_EXT, 32'h8000000B, value loaded into mcause when an interrupt is taken.

Ports:
- CLK  in  1  system clock, all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- INTR  in  1  external interrupt request, asynchronous, level.
- INT_TAKEN  in  1  one-cycle pulse from the control FSM: trap entry this cycle.
- MRET_EXEC  in  1  one-cycle pulse: MRET executing this cycle.
- CSR_WE  in  1  CSR write strobe (CSRRW/CSRRS/CSRRC writeback cycle).
- ADDR  in  12  CSR address, ir[31:20].
- WD  in  32  write data (rs1 for CSRRW, ALU result for CSRRS/CSRRC).
- PC  in  32  address of the instruction to resume at after the trap.
- RD  out  32  combinational read of CSR at ADDR.
- MEPC  out  32  current mepc.
- MTVEC  out  32  current mtvec.
- MIE_BIT  out  1  mstatus.MIE.
- INT_PENDING  out  1  registered pending flag AND MIE AND mie.MEIE.

Behaviour:
- Implemented CSRs, each with only the listed bits writable:
  - mstatus 0x300: bit3 MIE, bit7 MPIE; other bits read 0.
  - mie 0x304: bit11 MEIE; other bits read 0.
  - mtvec 0x305: bits[31:2]; [1:0] read 0 (direct mode only).
  - mepc 0x341: bits[31:2]; [1:0] read 0.
  - mcause 0x342: full 32 bits.
- Any other ADDR reads 32'h0; writes to it are ignored, with no side effect.
- Reset (RST=1 at edge):
  - all CSRs are 0, the synchronizer chain is 0, the pending flag is 0, the edge-detect history is 0.
  - Outputs after reset: RD=0 (for any ADDR), MEPC=0, MTVEC=0, MIE_BIT=0, INT_PENDING=0.
  - Reset overrides every other input, including mid-trap.
- Read: RD is purely combinational from ADDR and the current register state. A write is visible on RD the cycle after CSR_WE.
- Write: at the edge where CSR_WE=1, the addressed register takes WD masked to its writable bits.
- Interrupt capture:
  - INTR passes through SYNC_STAGES flops.
  - A rising edge of the synchronized signal sets the pending flag on the next edge.
  - The level alone does not re-arm; a new 0→1 edge is required.
- INT_PENDING = pending & mstatus.MIE & mie.MEIE, combinational from registers.
- INT_TAKEN=1 at an edge:
  - mepc ← {PC[31:2],2'b00}
  - mcause ← MCAUSE_EXT
  - MPIE ← MIE
  - MIE ← 0
  - pending ← 0, unless a synchronized rising edge occurs in the same cycle, in which case pending stays 1.
- MRET_EXEC=1 at an edge: MIE ← MPIE, MPIE ← 1. Other CSRs are unchanged.
- Simultaneous events, in priority order:
  - INT_TAKEN > MRET_EXEC > CSR_WE for any field they share.
  - INT_TAKEN with CSR_WE to mepc, mcause or mstatus: the trap values win.
  - A CSR_WE to an unrelated CSR (mtvec, mie) in the same cycle still commits.
  - MRET_EXEC with CSR_WE to mstatus: MRET values win. A CSR_WE to any other CSR commits.
  - INT_TAKEN with MRET_EXEC: treated as INT_TAKEN only.
- INT_TAKEN while INT_PENDING=0: the trap update still happens. It is the FSM's responsibility; no error is flagged.
- No backpressure and no multi-cycle operations. Every update has single-edge latency.

Test Plan:
- Reset check: RST=1 for 2 cycles with INTR=1 and CSR_WE=1, ADDR=0x305, WD=32'hFFFF_FFFF → after release MTVEC=0, MIE_BIT=0, INT_PENDING=0, RD(0x305)=0.
- Write masking: write mtvec WD=32'h0000_0107 → MTVEC=32'h0000_0104. Write mstatus WD=32'hFFFF_FFFF → RD(0x300)=32'h0000_0088, MIE_BIT=1. Write 0x123 with WD=5 → RD(0x123)=0.
- Interrupt latency and edge detect: mstatus=0x8, mie=0x800, INTR 0→1 held high → INT_PENDING rises exactly SYNC_STAGES+1 edges later (3 for the default) and stays high. Masked when MEIE=0.
- Trap entry: PC=32'h0000_1236, pulse INT_TAKEN → MEPC=32'h0000_1234, RD(0x342)=32'h8000000B, RD(0x300)=32'h0000_0080, INT_PENDING=0. INTR still high gives no re-trigger.
- MRET: from the post-trap state, pulse MRET_EXEC → RD(0x300)=32'h0000_0088, MIE_BIT=1, MEPC unchanged.
- Collisions:
  - INT_TAKEN with CSR_WE to 0x341 (WD=32'hDEAD_BEEC): MEPC=PC, not WD.
  - INT_TAKEN with CSR_WE to 0x305 (WD=32'h200): MTVEC=32'h200.
  - Fresh INTR edge arriving on the INT_TAKEN cycle: pending stays 1.
